tick_burst_scheduler: RTL
=========================

Name: tick_burst_scheduler

Overview:
Synchronous controller that sequences a 16-stage binary prescaler. It replaces the free-running ripple flip-flop divide chain with a clock-enable tick generator on the single system clock. Software or pin logic selects a tap, starts it, and runs it either continuously or for a fixed burst of ticks. Downstream logic consumes `tick` as a one-cycle enable. `tap_q` provides a square-wave view of the selected prescaler bit for the output pins.

Parameters:
- WIDTH, 16, prescaler counter width; the valid tap range is 0..WIDTH-1.
- CNT_W, 8, width of the burst-length input and of the tick counter.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  synchronous reset, active-high.
- start  input  1  level-sampled request to begin. Acted on only in IDLE.
- stop  input  1  level-sampled request to abort. Acted on in IDLE and RUN.
- oneshot  input  1  sampled with start. 1 = burst mode, 0 = continuous mode.
- tap_sel  input  4  sampled with start. Selects tick period 2^(tap_sel+1) cycles.
- burst_len  input  CNT_W  sampled with start. Number of ticks in a burst; 0 means 2^CNT_W.
- tick  output  1  registered one-cycle enable pulse.
- tap_q  output  1  selected prescaler bit. Forced to 0 when not in RUN.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse coinciding with the final tick of a burst.
- tick_count  output  CNT_W  number of ticks emitted since the last accepted start; wraps.

Behaviour:
- Reset (synchronous, rst=1 at an edge): state=IDLE. prescale, tick_count, latched cfg, tick, done, busy and tap_q are all 0. Reset overrides every other input. Reset mid-RUN aborts on that edge with no tick and no done.
- FSM states: IDLE, RUN, DONE.
- IDLE -> RUN on start=1 and stop=0. On that edge:
  - latch tap_sel, oneshot and burst_len;
  - clear prescale and tick_count.
- IDLE with start=1 and stop=1 remains in IDLE (stop wins).
- RUN behaviour on each edge:
  - prescale increments by 1 and wraps at 2^WIDTH.
  - tick_next = (prescale[tap:0] == all ones) AND stop=0. The prescale value used is the one held before the edge.
  - tick <= tick_next.
  - On tick_next, tick_count increments, wrapping from 2^CNT_W-1 to 0.
- Tick timing: with start accepted at edge E0, tick is high in the cycles following edges E0+P, E0+2P, …, where P = 2^(tap+1).
- RUN -> IDLE on stop=1. That edge emits no tick and no tick_count increment. prescale clears.
- RUN -> DONE when oneshot=1, tick_next=1, and (tick_count+1) mod 2^CNT_W == burst_len_latched. done is registered high on that same edge, so done coincides with the final tick.
- DONE lasts exactly one cycle, then goes to IDLE unconditionally. start and stop are ignored during DONE. tick_count holds its final value until the next accepted start.
- busy = (state==RUN). It drops in the cycle where done is high.
- Continuous mode (oneshot=0): never enters DONE; runs until stop or rst.
- tap_q = prescale[tap_latched] while in RUN, otherwise 0. In RUN it toggles every 2^tap cycles.
- Input handling:
  - start while in RUN is ignored.
  - Changes to tap_sel, oneshot or burst_len while in RUN are ignored.
  - A tap_sel value ≥ WIDTH is clamped to WIDTH-1 when latched.
- Width rules: prescale is WIDTH bits, unsigned. The compare uses the latched tap index. CNT_W arithmetic is modulo 2^CNT_W.

Test Plan:
- Continuous, tap_sel=0, start pulse at E0 -> tick high after E0+2, +4, +6, …; tick_count=5 after E0+10; busy=1 throughout; done never asserts.
- Burst, tap_sel=3, burst_len=3 -> ticks after E0+16, E0+32, E0+48. done=1 together with the third tick. busy=0 in that cycle. tick_count=3. IDLE after E0+49. tap_q toggles every 8 cycles while in RUN.
- Burst, tap_sel=0, burst_len=0 -> 256 ticks; done together with the tick after E0+512. tick_count reads 0 (wrapped).
- stop asserted at the edge where a tick is due (tap_sel=1, edge E0+8) -> no tick, tick_count=1, state IDLE, tap_q=0. A start at the same edge as the stop, with the block in IDLE, stays IDLE.
- tap_sel changed from 2 to 0 and start re-pulsed mid-RUN -> period stays 8 cycles and tick_count is not cleared. A tap_sel of 15 produces the first tick after E0+65536.
- rst=1 for one edge mid-burst (after 2 of 5 ticks) -> all outputs 0 on the next cycle with no done. A fresh start restarts tick_count from 0.

Source files
------------

// File: rtl/tick_burst_scheduler.sv
// tick_burst_scheduler: clock-enable tick generator over a binary prescaler, continuous or fixed-burst.
module tick_burst_scheduler #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             oneshot,
  input  logic [3:0]       tap_sel,
  input  logic [CNT_W-1:0] burst_len,
  output logic             tick,
  output logic             tap_q,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] tick_count
);
  localparam int TW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;
  logic [WIDTH-1:0] prescale, mask;
  logic [TW-1:0] tap_l;
  logic oneshot_l;
  logic [CNT_W-1:0] burst_l, count_inc;
  logic tick_next, last;
  assign mask = {WIDTH{1'b1}} >> (TW'(WIDTH - 1) - tap_l);
  assign tick_next = state == RUN && !stop && &(prescale | ~mask);
  assign count_inc = tick_count + 1'b1;
  assign last = oneshot_l && tick_next && count_inc == burst_l;
  assign busy = state == RUN;
  assign tap_q = busy && prescale[tap_l];
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      prescale   <= '0;
      tick_count <= '0;
      tap_l      <= '0;
      oneshot_l  <= 1'b0;
      burst_l    <= '0;
      tick       <= 1'b0;
      done       <= 1'b0;
    end else begin
      tick <= tick_next;
      done <= last;
      case (state)
        IDLE: if (start && !stop) begin
          state      <= RUN;
          tap_l      <= int'(tap_sel) >= WIDTH ? TW'(WIDTH - 1) : TW'(tap_sel);
          oneshot_l  <= oneshot;
          burst_l    <= burst_len;
          prescale   <= '0;
          tick_count <= '0;
        end
        RUN: if (stop) begin
          state    <= IDLE;
          prescale <= '0;
        end else begin
          prescale <= prescale + 1'b1;
          if (tick_next) tick_count <= count_inc;
          if (last) state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
